// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states,
// and the layout of the ACTIVE status register.
package irq_pkg;

  localparam logic [1:0] IRQ_REG_MASK    = 2'd0;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd1;
  localparam logic [1:0] IRQ_REG_ACTIVE  = 2'd2;
  localparam logic [1:0] IRQ_REG_SWTRIG  = 2'd3;

  localparam int IRQ_ACTIVE_BUSY_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    GAP     = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bundles the interrupt controller's source lines, core handshake and register
// port. master = core/software side, slave = the controller.
interface irq_ctrl_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] src;
  logic             irq;
  logic [31:0]      irq_addr;
  logic             irq_ack;
  logic             we;
  logic [1:0]       addr;
  logic [31:0]      wd;
  logic [31:0]      rd;

  modport master (
    output src, irq_ack, we, addr, wd,
    input  irq, irq_addr, rd
  );

  modport slave (
    input  src, irq_ack, we, addr, wd,
    output irq, irq_addr, rd
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins; idx is 0 when nothing
// is requested.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid = |req;
    idx   = '0;
    // Walk from the top down so the lowest requesting index overwrites last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the mips core: edge-detected pending bits,
// software mask, fixed priority, irq/irq_ack handshake with a one-cycle gap.
// Define IRQ_CTRL_SYNC_EN to put a 2-flop synchronizer on every src line.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               N_SRC      = 4,
  parameter logic [31:0]      VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0]      VEC_STRIDE = 32'h0000_0040,
  parameter logic [N_SRC-1:0] MASK_RST   = {N_SRC{1'b1}}
) (
  input logic          clk,
  input logic          rst,
  irq_ctrl_if.slave    bus
);

  logic [N_SRC-1:0] src_in;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] sw_set;
  logic [N_SRC-1:0] wr_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] eligible;
  logic             enc_valid;
  logic [2:0]       enc_idx;
  logic             ack_fire;

  irq_state_t  state, state_nxt;
  logic        irq_q, irq_nxt;
  logic [31:0] irq_addr_q, addr_nxt;
  logic [2:0]  id, id_nxt;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.src;
      sync2 <= sync1;
    end
  end

  assign src_in = sync2;
`else
  assign src_in = bus.src;
`endif

  assign rise     = src_in & ~src_q;
  assign sw_set   = (bus.we && bus.addr == IRQ_REG_SWTRIG)  ? bus.wd[N_SRC-1:0] : '0;
  assign wr_clr   = (bus.we && bus.addr == IRQ_REG_PENDING) ? bus.wd[N_SRC-1:0] : '0;
  assign ack_fire = (state == SERVICE) && bus.irq_ack;
  assign ack_clr  = ack_fire ? ((N_SRC)'(1) << id) : '0;
  assign eligible = pending & mask;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      src_q   <= src_in;
      // Sets are applied after clears so a new request wins over a clear.
      pending <= (pending & ~(wr_clr | ack_clr)) | rise | sw_set;
      if (bus.we && bus.addr == IRQ_REG_MASK) mask <= bus.wd[N_SRC-1:0];
    end
  end

  irq_prio_enc #(.N(N_SRC)) u_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq_q      <= 1'b0;
      irq_addr_q <= '0;
      id         <= '0;
    end else begin
      state      <= state_nxt;
      irq_q      <= irq_nxt;
      irq_addr_q <= addr_nxt;
      id         <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq_q;
    addr_nxt  = irq_addr_q;
    id_nxt    = id;
    unique case (state)
      IDLE: begin
        if (enc_valid) begin
          id_nxt    = enc_idx;
          irq_nxt   = 1'b1;
          addr_nxt  = VEC_BASE + VEC_STRIDE * {29'd0, enc_idx};
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        // Mask changes and higher-priority arrivals are ignored until ack.
        if (bus.irq_ack) begin
          irq_nxt   = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd = '0;
    unique case (bus.addr)
      IRQ_REG_MASK:    bus.rd = 32'(mask);
      IRQ_REG_PENDING: bus.rd = 32'(pending);
      IRQ_REG_ACTIVE: begin
        bus.rd[IRQ_ACTIVE_BUSY_BIT] = (state == SERVICE);
        bus.rd[2:0]                 = id;
      end
      default:         bus.rd = '0;
    endcase
  end

  assign bus.irq      = irq_q;
  assign bus.irq_addr = irq_addr_q;

  // Write data above the source count has no destination.
  logic unused_wd;
  assign unused_wd = ^bus.wd[31:N_SRC];

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle-level behavioural model compared every
// negedge, plus hand-computed literal checks on the scenarios of interest.
`timescale 1ns/100ps
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0040;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #10 clk = ~clk;

  irq_ctrl_if #(.N_SRC(N)) bus ();

  irq_ctrl #(
    .N_SRC      (N),
    .VEC_BASE   (BASE),
    .VEC_STRIDE (STRIDE),
    .MASK_RST   (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, mask, and "currently serving / in gap".
  logic [N-1:0] m_pend, m_mask, m_prev_view;
  logic [N-1:0] m_hist [0:3];
  logic         m_irq, m_busy, m_gap;
  logic [31:0]  m_addr;
  int           m_id;

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] view, rise, setv, clrv, elig;
    if (rst) begin
      m_pend = '0; m_mask = '1; m_prev_view = '0;
      m_irq = 1'b0; m_busy = 1'b0; m_gap = 1'b0; m_addr = '0; m_id = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
    end else begin
      view = (D == 0) ? bus.src : m_hist[D-1];
      rise = view & ~m_prev_view;
      setv = rise | ((bus.we && bus.addr == IRQ_REG_SWTRIG) ? bus.wd[N-1:0] : '0);
      clrv = (bus.we && bus.addr == IRQ_REG_PENDING) ? bus.wd[N-1:0] : '0;
      if (m_busy && bus.irq_ack) clrv[m_id] = 1'b1;
      elig = m_pend & m_mask;
      if (m_busy) begin
        if (bus.irq_ack) begin
          m_busy = 1'b0; m_irq = 1'b0; m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (elig != 0) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin
            m_id = i;
            break;
          end
        end
        m_busy = 1'b1;
        m_irq  = 1'b1;
        m_addr = BASE + STRIDE * m_id;
      end
      if (bus.we && bus.addr == IRQ_REG_MASK) m_mask = bus.wd[N-1:0];
      m_pend = (m_pend & ~clrv) | setv;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0]   = bus.src;
      m_prev_view = view;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      IRQ_REG_MASK:    v = 32'(m_mask);
      IRQ_REG_PENDING: v = 32'(m_pend);
      IRQ_REG_ACTIVE: begin
        v[31]  = m_busy;
        v[2:0] = 3'(m_id);
      end
      default:         v = '0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("model_irq", {31'd0, bus.irq}, {31'd0, m_irq});
      if (m_irq) check("model_irq_addr", bus.irq_addr, m_addr);
      check("model_rd", bus.rd, model_rd(bus.addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_at(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rd;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wd = d;
    tick();
    bus.we = 1'b0; bus.wd = '0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bus.src = '0; bus.irq_ack = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    ticks(3);
    rst = 1'b0;
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_irq_addr", bus.irq_addr, 32'd0);
    rd_at(IRQ_REG_MASK, v);    check("rst_mask", v, 32'hF);
    rd_at(IRQ_REG_PENDING, v); check("rst_pending", v, 32'h0);
    rd_at(IRQ_REG_ACTIVE, v);  check("rst_active", v, 32'h0);
    tick();

    // Single source: pending one edge after the rise, irq one edge later.
    bus.src = 4'b0100;
    ticks(D + 1);
    rd_at(IRQ_REG_PENDING, v); check("t1_pending", v, 32'h4);
    check("t1_irq_early", {31'd0, bus.irq}, 32'd0);
    tick();
    check("t1_irq", {31'd0, bus.irq}, 32'd1);
    check("t1_irq_addr", bus.irq_addr, 32'h80);
    rd_at(IRQ_REG_ACTIVE, v);  check("t1_active", v, 32'h8000_0002);
    ack();
    check("t1_ack_irq", {31'd0, bus.irq}, 32'd0);
    rd_at(IRQ_REG_PENDING, v); check("t1_ack_pending", v, 32'h0);
    tick();
    check("t1_gap_irq", {31'd0, bus.irq}, 32'd0);
    bus.src = '0;
    ticks(4);

    // Two simultaneous sources: id 1 first, id 3 after ack plus gap.
    bus.src = 4'b1010;
    ticks(D + 2);
    check("t2_irq_a", {31'd0, bus.irq}, 32'd1);
    check("t2_addr_a", bus.irq_addr, 32'h40);
    ack();
    check("t2_ack_irq", {31'd0, bus.irq}, 32'd0);
    tick();
    check("t2_gap_irq", {31'd0, bus.irq}, 32'd0);
    tick();
    check("t2_irq_b", {31'd0, bus.irq}, 32'd1);
    check("t2_addr_b", bus.irq_addr, 32'hC0);
    ack();
    ticks(2);
    rd_at(IRQ_REG_PENDING, v); check("t2_pending", v, 32'h0);
    bus.src = '0;
    ticks(4);

    // Mask: bits above N_SRC dropped; masked source pends without irq.
    reg_write(IRQ_REG_MASK, 32'hFFFF_FFFE);
    rd_at(IRQ_REG_MASK, v);    check("t3_mask_rd", v, 32'hE);
    bus.src = 4'b0001;
    ticks(D + 1);
    rd_at(IRQ_REG_PENDING, v); check("t3_pending", v, 32'h1);
    ticks(2);
    check("t3_masked_irq", {31'd0, bus.irq}, 32'd0);
    reg_write(IRQ_REG_MASK, 32'h0000_000F);
    tick();
    check("t3_unmask_irq", {31'd0, bus.irq}, 32'd1);
    check("t3_unmask_addr", bus.irq_addr, 32'h0);
    ack();
    tick();
    bus.src = '0;
    ticks(4);

    // Software trigger, then a hardware edge on the same bit coinciding with ack.
    reg_write(IRQ_REG_SWTRIG, 32'h0000_0002);
    rd_at(IRQ_REG_SWTRIG, v);  check("t4_swtrig_rd", v, 32'h0);
    rd_at(IRQ_REG_PENDING, v); check("t4_pending", v, 32'h2);
    tick();
    check("t4_irq", {31'd0, bus.irq}, 32'd1);
    check("t4_addr", bus.irq_addr, 32'h40);
    bus.src = 4'b0010;
    ticks(D);
    ack();
    check("t4_ack_irq", {31'd0, bus.irq}, 32'd0);
    rd_at(IRQ_REG_PENDING, v); check("t4_repend", v, 32'h2);
    tick();
    check("t4_gap_irq", {31'd0, bus.irq}, 32'd0);
    tick();
    check("t4_reirq", {31'd0, bus.irq}, 32'd1);
    check("t4_readdr", bus.irq_addr, 32'h40);
    ack();
    ticks(2);
    bus.src = '0;
    ticks(4);

    // Asynchronous reset in the middle of servicing id 2.
    bus.src = 4'b0100;
    ticks(D + 2);
    check("t5_irq", {31'd0, bus.irq}, 32'd1);
    check("t5_addr", bus.irq_addr, 32'h80);
    bus.src = '0;
    rst = 1'b1;
    #1;
    check("t5_rst_irq", {31'd0, bus.irq}, 32'd0);
    check("t5_rst_addr", bus.irq_addr, 32'h0);
    rd_at(IRQ_REG_MASK, v);    check("t5_rst_mask", v, 32'hF);
    rd_at(IRQ_REG_PENDING, v); check("t5_rst_pending", v, 32'h0);
    rd_at(IRQ_REG_ACTIVE, v);  check("t5_rst_active", v, 32'h0);
    rst = 1'b0;
    ticks(3);
    check("t5_post_irq", {31'd0, bus.irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
